// File: rtl/onehot_scan_decoder.sv
// onehot_scan_decoder: registered N-to-2^N one-hot decoder with enable and dwell-timed auto-scan
module onehot_scan_decoder #(
  parameter int N       = 3,
  parameter int DWELL_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               mode,
  input  logic [N-1:0]       in,
  input  logic [DWELL_W-1:0] dwell,
  output logic [(1<<N)-1:0]  out,
  output logic [N-1:0]       idx,
  output logic               wrap,
  output logic               busy
);
  localparam int L = 1 << N;
  localparam logic [L-1:0] one = L'(1);
  typedef enum logic [1:0] {IDLE, DIRECT, SCAN} state_t;
  state_t state;
  logic [DWELL_W-1:0] cnt, dwell_q;
  logic [N-1:0] nxt;
  assign nxt = idx + N'(1);
  // en=0 outranks mode; any non-SCAN state entering SCAN is an entry and latches dwell
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      out     <= '0;
      idx     <= '0;
      wrap    <= 1'b0;
      busy    <= 1'b0;
      cnt     <= '0;
      dwell_q <= '0;
    end else if (!en) begin
      state <= IDLE;
      out   <= '0;
      wrap  <= 1'b0;
      busy  <= 1'b0;
      cnt   <= '0;
    end else if (!mode) begin
      state <= DIRECT;
      out   <= one << in;
      idx   <= in;
      wrap  <= 1'b0;
      busy  <= 1'b0;
      cnt   <= '0;
    end else if (state != SCAN) begin
      state   <= SCAN;
      out     <= one << in;
      idx     <= in;
      wrap    <= 1'b0;
      busy    <= 1'b1;
      cnt     <= '0;
      dwell_q <= dwell;
    end else if (cnt != dwell_q) begin
      cnt  <= cnt + DWELL_W'(1);
      wrap <= 1'b0;
    end else begin
      cnt  <= '0;
      idx  <= nxt;
      out  <= one << nxt;
      wrap <= &idx;
    end
  end
endmodule

// File: tb/tb_onehot_scan_decoder.sv
// tb_onehot_scan_decoder: directed stimulus with a queued scoreboard checked by an independent monitor
module tb_onehot_scan_decoder;
  logic clk = 1'b0, rst = 1'b1, en = 1'b0, mode = 1'b0;
  logic [2:0] in = '0;
  logic [3:0] dwell = '0;
  logic [7:0] out;
  logic [2:0] idx;
  logic wrap, busy;
  int n_chk = 0, n_fail = 0;
  typedef struct packed {logic [7:0] o; logic [2:0] i; logic w; logic b;} exp_t;
  exp_t q[$];
  string nq[$];

  onehot_scan_decoder #(.N(3), .DWELL_W(4)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .in(in), .dwell(dwell),
    .out(out), .idx(idx), .wrap(wrap), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input exp_t e);
    n_chk++;
    if ({out, idx, wrap, busy} !== {e.o, e.i, e.w, e.b}) begin
      n_fail++;
      $display("FAIL %s: got out=%b idx=%0d wrap=%b busy=%b, expected out=%b idx=%0d wrap=%b busy=%b",
               nm, out, idx, wrap, busy, e.o, e.i, e.w, e.b);
    end
  endtask

  task automatic step(input logic e, input logic m, input logic [2:0] s, input logic [3:0] d,
                      input logic [7:0] eo, input logic [2:0] ei, input logic ew, input logic eb,
                      input string nm);
    exp_t x;
    x = '{o: eo, i: ei, w: ew, b: eb};
    en = e; mode = m; in = s; dwell = d;
    q.push_back(x);
    nq.push_back(nm);
    @(posedge clk);
    #2;
  endtask

  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        x = q.pop_front();
        chk(nq.pop_front(), x);
      end
    end
  end

  initial begin
    logic [2:0] line;
    int t;
    #3;
    chk("reset_initial", '{o: 8'h00, i: 3'd0, w: 1'b0, b: 1'b0});
    @(posedge clk);
    #2;
    rst = 1'b0;
    // direct sweep
    for (int i = 0; i < 8; i++)
      step(1, 0, 3'(i), 0, 8'(1 << i), 3'(i), 0, 0, $sformatf("direct_%0d", i));
    // enable gating, idx holds the last line
    step(0, 1, 3'd5, 0, 8'h00, 3'd7, 0, 0, "gate_off_mode1");
    step(0, 0, 3'd2, 0, 8'h00, 3'd7, 0, 0, "gate_off_mode0");
    step(1, 0, 3'd3, 0, 8'b0000_1000, 3'd3, 0, 0, "gate_on_in3");
    // scan from line 6, dwell 2; in changes after entry are ignored
    for (t = 0; t < 27; t++) begin
      line = 3'((6 + t / 3) % 8);
      step(1, 1, t == 0 ? 3'd6 : 3'd1, 4'd2, 8'(1 << line), line,
           t > 0 && t % 3 == 0 && line == 0, 1, $sformatf("scan_d2_t%0d", t));
    end
    step(0, 1, 3'd0, 0, 8'h00, 3'd6, 0, 0, "scan_to_idle");
    // dwell latched as 0 at entry; later dwell=7 must not slow the scan
    step(1, 1, 3'd0, 4'd0, 8'h01, 3'd0, 0, 1, "scan_entry_in0_nowrap");
    for (t = 1; t < 18; t++) begin
      line = 3'(t % 8);
      step(1, 1, 3'd4, 4'd7, 8'(1 << line), line, line == 0, 1, $sformatf("latch_t%0d", t));
    end
    // scan -> direct -> scan re-entry
    step(1, 0, 3'd2, 4'd7, 8'b0000_0100, 3'd2, 0, 0, "scan_to_direct");
    step(1, 1, 3'd2, 4'd1, 8'b0000_0100, 3'd2, 0, 1, "reentry_line2");
    for (t = 1; t < 7; t++) begin
      line = 3'(2 + t / 2);
      step(1, 1, 3'd0, 4'd1, 8'(1 << line), line, 0, 1, $sformatf("reentry_t%0d", t));
    end
    // asynchronous reset mid-scan at idx=5
    #1 rst = 1'b1;
    #1 chk("reset_async_midscan", '{o: 8'h00, i: 3'd0, w: 1'b0, b: 1'b0});
    @(posedge clk);
    #2;
    chk("reset_held_edge", '{o: 8'h00, i: 3'd0, w: 1'b0, b: 1'b0});
    rst = 1'b0;
    step(1, 1, 3'd4, 4'd0, 8'b0001_0000, 3'd4, 0, 1, "post_reset_entry");
    step(1, 1, 3'd0, 4'd0, 8'b0010_0000, 3'd5, 0, 1, "post_reset_step");
    step(1, 0, 3'd7, 4'd0, 8'b1000_0000, 3'd7, 0, 0, "post_reset_direct");
    for (int k = 0; k < 20 && q.size() > 0; k++) @(posedge clk);
    #3;
    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expected entries left, required 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
